// File: rtl/flash_uart_tx_buf_pkg.sv
// ---------------------------------------------------------------------------
// flash_uart_tx_buf_pkg
//   Shared constants for the flash-to-UART transmit buffer: the UART frame
//   geometry (8 data bits, 10 bits per 8N1 frame) and the encodings of the
//   transmit FSM states. The states are plain 2-bit constants so that older
//   tools and netlists see a fixed encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package flash_uart_tx_buf_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/flash_uart_tx_buf_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered storage, an occupancy count and a full
//   flag. A push and a pop may happen in the same cycle; when the FIFO is full
//   a push is still accepted if a pop happens in that cycle.
//   Ports:
//     clk      in   1        clock, rising edge
//     rst      in   1        synchronous active-high reset, empties the FIFO
//     i_push   in   1        write request
//     i_din    in   WIDTH    write data
//     i_pop    in   1        read request (ignored while empty)
//     o_dout   out  WIDTH    head of the FIFO
//     o_full   out  1        count == DEPTH
//     o_count  out  AW+1     number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_din;
  end

  assign o_dout  = r_mem[r_rdPtr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/flash_uart_tx_buf.sv
// ---------------------------------------------------------------------------
// flash_uart_tx_buf
//   Takes bytes strobed out of the SPI flash reader, buffers them in a small
//   FIFO and sends them on a UART line, 8N1, LSB first. The FIFO soaks up the
//   SPI burst rate against the much slower UART rate.
//   Ports:
//     sys_clk    in   1  system clock, rising edge
//     sys_rst    in   1  synchronous active-high reset
//     pi_data    in   8  byte read from flash
//     pi_flag    in   1  one-cycle strobe, pi_data valid
//     tx         out  1  UART serial output, idle high (registered)
//     busy       out  1  frame on the line or FIFO non-empty
//     fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
//     overflow   out  1  sticky: a strobe was dropped on a full FIFO
// ---------------------------------------------------------------------------
module flash_uart_tx_buf #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  import flash_uart_tx_buf_pkg::*;

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int FIFO_AW      = $clog2(FIFO_DEPTH);
  localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic [1:0]           r_state;
  logic [BAUD_W-1:0]    r_baudCnt;
  logic [BIT_W-1:0]     r_bitCnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_tx;
  logic                 r_overflow;

  logic [7:0]           w_fifoDout;
  logic                 w_fifoFull;
  logic [FIFO_AW:0]     w_fifoCount;
  logic                 w_fifoEmpty;
  logic                 w_pop;

  assign w_fifoEmpty = (w_fifoCount == '0);
  assign w_pop       = (r_state == ST_IDLE) && !w_fifoEmpty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_push  (pi_flag),
    .i_din   (pi_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifoDout),
    .o_full  (w_fifoFull),
    .o_count (w_fifoCount)
  );

  // tx is registered from the current state, so the line lags the FSM by one
  // clock; every bit still lasts exactly BAUD_CNT_MAX clocks.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx      <= 1'b1;
          r_baudCnt <= '0;
          if (!w_fifoEmpty) begin
            r_shreg <= w_fifoDout;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (r_baudCnt == BAUD_LAST) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_state   <= ST_DATA;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        ST_DATA: begin
          r_tx <= r_shreg[0];
          if (r_baudCnt == BAUD_LAST) begin
            r_baudCnt <= '0;
            r_shreg   <= r_shreg >> 1;
            if (r_bitCnt == BIT_LAST) begin
              r_state <= ST_STOP;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (r_baudCnt == BAUD_LAST) begin
            r_baudCnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        default: begin
          r_tx      <= 1'b1;
          r_baudCnt <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // A strobe is only lost when the FIFO is full and nothing leaves it that cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_overflow <= 1'b0;
    end else if (pi_flag && w_fifoFull && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx        = r_tx;
  assign busy      = (r_state != ST_IDLE) || !w_fifoEmpty;
  assign fifo_full = w_fifoFull;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_flash_uart_tx_buf.sv
// ---------------------------------------------------------------------------
// tb_flash_uart_tx_buf
//   Drives directed strobe patterns into flash_uart_tx_buf (4 clocks per UART
//   bit, 4-entry FIFO). Accepted bytes are queued as they are strobed in; an
//   independent UART receiver on tx decodes frames and compares each against
//   the head of that queue.
// ---------------------------------------------------------------------------
module tb_flash_uart_tx_buf;

  localparam int BAUD       = 4;
  localparam int FRAME_CLKS = 10 * BAUD;
  localparam int DEPTH      = 4;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] piData  = 8'h00;
  logic       piFlag  = 1'b0;
  logic       tx;
  logic       busy;
  logic       fifoFull;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];
  int         startCycles[$];
  int         negCycle   = 0;
  int         monPhase   = -1;
  logic [7:0] monByte    = 8'h00;
  int         framesSeen = 0;

  // Occupancy model: mRem counts clocks until the transmitter is idle again.
  int mCnt          = 0;
  int mRem          = 0;
  bit mOverflow     = 1'b0;
  int acceptedCount = 0;

  flash_uart_tx_buf #(
    .CLK_FREQ   (1_000_000),
    .UART_BPS   (250_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk   (clock),
    .sys_rst   (reset),
    .pi_data   (piData),
    .pi_flag   (piFlag),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifoFull),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // UART receiver: phase 0 is the first falling-edge sample showing the start bit.
  always @(negedge clock) begin
    negCycle++;
    if (reset) begin
      monPhase = -1;
    end else if (monPhase < 0) begin
      if (tx === 1'b0) begin
        monPhase = 0;
        startCycles.push_back(negCycle);
      end
    end else begin
      monPhase++;
      if (monPhase == 2) begin
        checkOutput("mon_start_bit", {31'd0, tx}, 32'd0);
      end else if (monPhase >= 5 && monPhase <= 33 && ((monPhase - 5) % 4) == 0) begin
        monByte[(monPhase - 5) / 4] = tx;
      end else if (monPhase == 37) begin
        checkOutput("mon_stop_bit", {31'd0, tx}, 32'd1);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL mon_unexpected_frame actual=0x%0h expected=none", monByte);
        end else begin
          checkOutput("mon_frame_byte", {24'd0, monByte}, {24'd0, expQ.pop_front()});
        end
        framesSeen++;
        monPhase = -1;
      end
    end
  end

  task automatic applyStimulus(input bit flag, input logic [7:0] data);
    bit pop;
    piFlag = flag;
    piData = data;
    @(posedge clock);
    pop = (mRem == 0) && (mCnt > 0);
    if (mRem > 0) mRem--;
    if (pop) begin
      mRem = FRAME_CLKS;
      mCnt--;
    end
    if (flag) begin
      if (mCnt < DEPTH) begin
        mCnt++;
        expQ.push_back(data);
        acceptedCount++;
      end else begin
        mOverflow = 1'b1;
      end
    end
    #1;
    piFlag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic doReset();
    reset  = 1'b1;
    piFlag = 1'b0;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    mCnt      = 0;
    mRem      = 0;
    mOverflow = 1'b0;
    expQ.delete();
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((expQ.size() != 0 || monPhase >= 0 || mCnt != 0 || mRem != 0) && n < budget) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    checkOutput(name, {31'd0, (n < budget)}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pattern;
    logic [7:0] rb;
    int         s0;
    int         f0;
    int         a0;

    // Test 1: reset state, single 0xA5 frame with latency and bit timing
    doReset();
    doReset();
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_fifo_full", {31'd0, fifoFull}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    pattern = 8'hA5;
    applyStimulus(1'b1, 8'hA5);
    checkOutput("t1_busy_after_strobe", {31'd0, busy}, 32'd1);
    idle(1);
    checkOutput("t1_tx_high_edge1", {31'd0, tx}, 32'd1);
    idle(1);
    checkOutput("t1_tx_low_edge2", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      idle(4);
      checkOutput($sformatf("t1_data_bit%0d", i), {31'd0, tx}, {31'd0, pattern[i]});
    end
    idle(4);
    checkOutput("t1_stop_bit", {31'd0, tx}, 32'd1);
    idle(2);
    checkOutput("t1_busy_edge40", {31'd0, busy}, 32'd1);
    idle(1);
    checkOutput("t1_busy_edge41", {31'd0, busy}, 32'd0);
    waitDrain("t1_drain", 200);

    // Test 2: four back-to-back strobes, one idle clock between frames
    doReset();
    s0 = startCycles.size();
    f0 = framesSeen;
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h3C);
    waitDrain("t2_drain", 400);
    checkOutput("t2_frames", framesSeen - f0, 32'd4);
    checkOutput("t2_overflow", {31'd0, overflow}, 32'd0);
    if (startCycles.size() >= s0 + 4) begin
      for (int k = 1; k < 4; k++) begin
        checkOutput($sformatf("t2_frame_period%0d", k), startCycles[s0 + k] - startCycles[s0 + k - 1], FRAME_CLKS + 1);
      end
    end

    // Test 3: six strobes into a 4-deep FIFO, last one dropped
    doReset();
    f0 = framesSeen;
    for (int b = 1; b <= 5; b++) applyStimulus(1'b1, 8'(b));
    checkOutput("t3_fifo_full", {31'd0, fifoFull}, 32'd1);
    checkOutput("t3_overflow_before", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b1, 8'h06);
    checkOutput("t3_overflow_set", {31'd0, overflow}, 32'd1);
    waitDrain("t3_drain", 400);
    checkOutput("t3_frames", framesSeen - f0, 32'd5);
    checkOutput("t3_overflow_held", {31'd0, overflow}, 32'd1);
    checkOutput("t3_fifo_not_full", {31'd0, fifoFull}, 32'd0);

    // Test 4: strobe on a full FIFO in the same cycle as the pop
    doReset();
    f0 = framesSeen;
    applyStimulus(1'b1, 8'h10);
    for (int b = 0; b < 4; b++) applyStimulus(1'b1, 8'h11 + 8'(b));
    idle(37);
    checkOutput("t4_full_before_pop", {31'd0, fifoFull}, 32'd1);
    applyStimulus(1'b1, 8'h15);
    checkOutput("t4_full_after_pop_push", {31'd0, fifoFull}, 32'd1);
    checkOutput("t4_overflow", {31'd0, overflow}, 32'd0);
    waitDrain("t4_drain", 600);
    checkOutput("t4_frames", framesSeen - f0, 32'd6);
    checkOutput("t4_overflow_end", {31'd0, overflow}, 32'd0);

    // Test 5: reset during data bit 3 of 0x81, then a clean 0x42 frame
    doReset();
    applyStimulus(1'b1, 8'h81);
    idle(18);
    checkOutput("t5_bit3_before_reset", {31'd0, tx}, 32'd0);
    doReset();
    checkOutput("t5_tx_after_reset", {31'd0, tx}, 32'd1);
    checkOutput("t5_busy_after_reset", {31'd0, busy}, 32'd0);
    checkOutput("t5_full_after_reset", {31'd0, fifoFull}, 32'd0);
    f0 = framesSeen;
    applyStimulus(1'b1, 8'h42);
    waitDrain("t5_drain", 200);
    checkOutput("t5_frames", framesSeen - f0, 32'd1);

    // Test 6: random bytes at random gaps until 200 bytes are accepted
    doReset();
    f0 = framesSeen;
    a0 = acceptedCount;
    while (acceptedCount - a0 < 200) begin
      rb = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, rb);
      idle($urandom_range(0, 60));
    end
    waitDrain("t6_drain", 2000);
    checkOutput("t6_frames", framesSeen - f0, 32'd200);
    checkOutput("t6_overflow", {31'd0, overflow}, {31'd0, mOverflow});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
